// File: rtl/serial_ripple_subtractor_pkg.sv
// serial_ripple_subtractor_pkg: shared FSM state codes and default operand width
package serial_ripple_subtractor_pkg;
  localparam int DEF_WIDTH = 4;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SUB  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/serial_ripple_subtractor_fs.sv
// full_subtractor: one-bit difference and borrow-out of a - b - bin
// ports: a, b, bin in; d difference, bout borrow-out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor: bit-serial A - B - bin, LSB first, start/busy/done handshake
// ports: clk, rst (sync, active-high); start, A, B, bin captured in IDLE;
//        D, bout registered result held until the next completion; busy in SUB; done in DONE
module serial_ripple_subtractor
  import serial_ripple_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic [WIDTH-1:0] D,
  output logic             bout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic br_q, br_d, bo_q, bo_d;
  logic di, bn;
  full_subtractor u_fs (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .bin (br_q),
    .d   (di),
    .bout(bn)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bo_d    = bo_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SUB;
        a_d     = A;
        b_d     = B;
        br_d    = bin;
        cnt_d   = '0;
        r_d     = '0;
      end
      SUB: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = {di, r_q[WIDTH-1:1]};
        br_d  = bn;
        cnt_d = cnt_q + 1'b1;
        // last bit: publish the fully shifted result including this cycle's bit
        if (cnt_q == LAST) begin
          state_d = DONE;
          d_d     = {di, r_q[WIDTH-1:1]};
          bo_d    = bn;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
    end
  end
  assign D    = d_q;
  assign bout = bo_q;
  assign busy = state_q == SUB;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb_serial_ripple_subtractor: directed and sweep checks of the serial subtractor at WIDTH 4 and 8
module tb_serial_ripple_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] a_in[2], b_in[2], d_o[2];
  logic bin_in[2], st_in[2], bo_o[2], busy_o[2], done_o[2];
  logic [3:0] d4;
  logic [7:0] d8;
  int errors = 0, checks = 0, cyc = 0;
  int k[2], ed[2], ca[2], cb[2], cbn[2], eb[2], last[2];
  bit b2b = 0;
  always #5 clk = ~clk;
  serial_ripple_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(st_in[0]), .A(a_in[0][3:0]), .B(b_in[0][3:0]), .bin(bin_in[0]),
    .D(d4), .bout(bo_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );
  serial_ripple_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st_in[1]), .A(a_in[1]), .B(b_in[1]), .bin(bin_in[1]),
    .D(d8), .bout(bo_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );
  assign d_o[0] = {4'h0, d4};
  assign d_o[1] = d8;
  function automatic int wid(int i);
    return i == 0 ? 4 : 8;
  endfunction
  // model: k counts cycles since the accepted start; result appears W cycles later
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        k[i] = 0; ed[i] = 0; eb[i] = 0;
      end else if (k[i] == 0) begin
        if (st_in[i]) begin
          ca[i] = int'(a_in[i]) & ((1 << wid(i)) - 1);
          cb[i] = int'(b_in[i]) & ((1 << wid(i)) - 1);
          cbn[i] = int'(bin_in[i]);
          k[i] = 1;
        end
      end else if (k[i] == wid(i)) begin
        k[i] = wid(i) + 1;
        ed[i] = (ca[i] - cb[i] - cbn[i]) & ((1 << wid(i)) - 1);
        eb[i] = (ca[i] < cb[i] + cbn[i]) ? 1 : 0;
      end else if (k[i] == wid(i) + 1) k[i] = 0;
      else k[i] = k[i] + 1;
    end
  end
  task automatic chk(input string n, input int i, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s w%0d cyc %0d: got %0h want %0h", n, wid(i), cyc, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      chk("busy", i, int'(busy_o[i]), (k[i] >= 1 && k[i] <= wid(i)) ? 1 : 0);
      chk("done", i, int'(done_o[i]), k[i] == wid(i) + 1 ? 1 : 0);
      chk("D", i, int'(d_o[i]), ed[i]);
      chk("bout", i, int'(bo_o[i]), eb[i]);
      if (b2b && done_o[i]) begin
        if (last[i] >= 0) chk("spacing", i, cyc - last[i], wid(i) + 2);
        last[i] = cyc;
      end
    end
  endtask
  task automatic run(input int i, input int a, input int b, input int bi, input int el, input int bl);
    int nb, to;
    a_in[i] = 8'(a); b_in[i] = 8'(b); bin_in[i] = bi[0]; st_in[i] = 1'b1;
    tick();
    st_in[i] = 1'b0;
    nb = 0; to = 0;
    while (!done_o[i] && to < 30) begin
      nb += int'(busy_o[i]);
      tick();
      to++;
    end
    chk("done_seen", i, int'(done_o[i]), 1);
    chk("lit_D", i, int'(d_o[i]), el);
    chk("lit_bout", i, int'(bo_o[i]), bl);
    chk("busy_cycles", i, nb, wid(i));
    tick();
    chk("done_single", i, int'(done_o[i]), 0);
  endtask
  task automatic sweep(input int i, input int n, input bit scramble);
    int to;
    b2b = 1; last[i] = -1; st_in[i] = 1'b1;
    for (int v = 0; v < n; v++) begin
      if (scramble) begin
        a_in[i] = 8'($urandom); b_in[i] = 8'($urandom); bin_in[i] = 1'($urandom);
      end else begin
        a_in[i] = 8'(v & 15); b_in[i] = 8'((v >> 4) & 15); bin_in[i] = 1'((v >> 8) & 1);
      end
      tick();
      to = 0;
      while ((busy_o[i] || done_o[i]) && to < 30) begin
        if (scramble) begin
          a_in[i] = 8'($urandom); b_in[i] = 8'($urandom); bin_in[i] = 1'($urandom);
        end
        tick();
        to++;
      end
      chk("op_bound", i, to, wid(i) + 1);
    end
    st_in[i] = 1'b0; b2b = 0;
  endtask
  initial begin
    int dn, to;
    for (int i = 0; i < 2; i++) begin
      a_in[i] = '0; b_in[i] = '0; bin_in[i] = 1'b0; st_in[i] = 1'b0; last[i] = -1;
    end
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_D", 0, int'(d_o[0]), 0);
    chk("rst_busy", 1, int'(busy_o[1]), 0);
    run(0, 5, 3, 0, 2, 0);
    run(0, 3, 5, 0, 'hE, 1);
    run(0, 0, 0, 1, 'hF, 1);
    run(0, 'hF, 'hF, 0, 0, 0);
    run(1, 'h10, 'h01, 1, 'h0E, 0);
    run(1, 0, 'hFF, 1, 0, 1);
    run(1, 'hC8, 'h37, 0, 'h91, 0);
    a_in[0] = 8'd9; b_in[0] = 8'd4; bin_in[0] = 1'b0; st_in[0] = 1'b1;
    tick();
    a_in[0] = 8'd1; b_in[0] = 8'd1;
    dn = 0; to = 0;
    while ((busy_o[0] || done_o[0]) && to < 30) begin
      dn += int'(done_o[0]);
      tick();
      to++;
    end
    st_in[0] = 1'b0;
    chk("ign_done_count", 0, dn, 1);
    chk("ign_D", 0, int'(d_o[0]), 5);
    chk("ign_bout", 0, int'(bo_o[0]), 0);
    a_in[0] = 8'd7; b_in[0] = 8'd2; st_in[0] = 1'b1;
    tick();
    st_in[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 0, int'(busy_o[0]), 0);
    chk("abort_done", 0, int'(done_o[0]), 0);
    chk("abort_D", 0, int'(d_o[0]), 0);
    chk("abort_bout", 0, int'(bo_o[0]), 0);
    dn = 0;
    repeat (12) begin
      tick();
      dn += int'(done_o[0]);
    end
    chk("abort_no_done", 0, dn, 0);
    sweep(0, 512, 1'b0);
    sweep(1, 300, 1'b1);
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
